// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, default widths and write FSM states
package fb_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int FB_ADDR_W = 19;
  localparam int FB_DATA_W = 12;
  typedef enum logic {IDLE, ACK} wr_state_e;
endpackage

// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: holds a page swap pending until vertical blank, then toggles the displayed page
module fb_swap_ctrl
  import fb_pkg::*;
(
  input  logic clk,
  input  logic i_sclr,
  input  logic i_swap_req,
  input  logic i_vblank_start,
  output logic o_swap_busy,
  output logic o_swap_done,
  output logic o_disp_page
);
  logic pending_q, pending_d, page_q, page_d, done_q, swap;
  always_comb begin
    swap = i_vblank_start & (pending_q | i_swap_req);
    pending_d = ~swap & (pending_q | i_swap_req);
    page_d = page_q ^ swap;
  end
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      pending_q <= 1'b0;
      page_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      page_q <= page_d;
      done_q <= swap;
    end
  end
  assign o_swap_busy = pending_q;
  assign o_swap_done = done_q;
  assign o_disp_page = page_q;
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer arbiter; scan-out reads win, writer takes the spare cycles
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              i_sclr,
  input  logic              i_px_clk,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_swap_req,
  input  logic              i_vblank_start,
  output logic              o_swap_busy,
  output logic              o_swap_done,
  output logic              o_disp_page,
  output logic [ADDR_W:0]   o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  wr_state_e state_q, state_d;
  logic rd_slot, wr_go, rd_p1_q, rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  fb_swap_ctrl u_swap (
    .clk           (clk),
    .i_sclr        (i_sclr),
    .i_swap_req    (i_swap_req),
    .i_vblank_start(i_vblank_start),
    .o_swap_busy   (o_swap_busy),
    .o_swap_done   (o_swap_done),
    .o_disp_page   (o_disp_page)
  );
  // Writes target the back page, reads the displayed one
  always_comb begin
    rd_slot = i_px_clk & i_rd_req;
    wr_go = (state_q == IDLE) & i_wr_req & ~rd_slot & ~o_swap_busy & ~i_sclr;
    state_d = wr_go ? ACK : IDLE;
    o_mem_addr = rd_slot ? {o_disp_page, i_rd_addr} : wr_go ? {~o_disp_page, i_wr_addr} : '0;
    o_mem_we = wr_go;
    o_mem_wdata = wr_go ? i_wr_data : '0;
  end
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q <= IDLE;
      rd_p1_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      rd_p1_q <= rd_slot;
      rd_valid_q <= rd_p1_q;
      if (rd_p1_q) rd_data_q <= i_mem_rdata;
    end
  end
  assign o_wr_ack = (state_q == ACK);
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data = rd_data_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed scenario checks of fb_arbiter against a behavioural RAM
module tb_fb_arbiter;
  logic clk = 1'b0;
  logic i_sclr, i_px_clk, i_rd_req, i_wr_req, i_swap_req, i_vblank_start;
  logic [18:0] i_rd_addr, i_wr_addr;
  logic [11:0] i_wr_data, i_mem_rdata, o_rd_data, o_mem_wdata;
  logic o_rd_valid, o_wr_ack, o_swap_busy, o_swap_done, o_disp_page, o_mem_we;
  logic [19:0] o_mem_addr;
  logic [11:0] ram [0:(1<<20)-1];
  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
    i_mem_rdata <= ram[o_mem_addr];
  end

  fb_arbiter dut (
    .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk), .i_rd_req(i_rd_req),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ack(o_wr_ack), .i_swap_req(i_swap_req), .i_vblank_start(i_vblank_start),
    .o_swap_busy(o_swap_busy), .o_swap_done(o_swap_done), .o_disp_page(o_disp_page),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ntests++; if (o_rd_valid !== 1'b0 || o_disp_page !== 1'b0 || o_swap_busy !== 1'b0) begin
      $display("FAIL reset_state: valid=%b page=%b busy=%b required 0 0 0", o_rd_valid, o_disp_page, o_swap_busy); nfail++; end
    i_px_clk = 1; i_rd_req = 1; i_rd_addr = 19'd3;
    tick;
    i_px_clk = 0; i_rd_req = 0; i_sclr = 1; i_wr_req = 1; i_wr_addr = 19'd1; i_wr_data = 12'hFFF;
    #1;
    ntests++; if (o_mem_we !== 1'b0) begin
      $display("FAIL reset_we_blocked: got %b required 0", o_mem_we); nfail++; end
    tick;
    i_sclr = 0; i_wr_req = 0;
    #1;
    ntests++; if (o_rd_valid !== 1'b0 || o_disp_page !== 1'b0 || o_wr_ack !== 1'b0 || o_swap_done !== 1'b0 || o_swap_busy !== 1'b0) begin
      $display("FAIL reset_midread: valid=%b page=%b ack=%b done=%b busy=%b required all 0", o_rd_valid, o_disp_page, o_wr_ack, o_swap_done, o_swap_busy); nfail++; end
    tick;
    ntests++; if (o_rd_valid !== 1'b0) begin
      $display("FAIL reset_flush: valid=%b required 0", o_rd_valid); nfail++; end
  endtask

  task automatic test_read;
    ram[5] = 12'hABC;
    i_px_clk = 1; i_rd_req = 1; i_rd_addr = 19'd5;
    #1;
    ntests++; if (o_mem_addr !== 20'h00005 || o_mem_we !== 1'b0) begin
      $display("FAIL read_addr: addr=%h we=%b required 00005 0", o_mem_addr, o_mem_we); nfail++; end
    tick;
    i_px_clk = 0; i_rd_req = 0;
    #1;
    ntests++; if (o_rd_valid !== 1'b0) begin
      $display("FAIL read_early: valid=%b required 0", o_rd_valid); nfail++; end
    tick;
    ntests++; if (o_rd_valid !== 1'b1 || o_rd_data !== 12'hABC) begin
      $display("FAIL read_data: valid=%b data=%h required 1 abc", o_rd_valid, o_rd_data); nfail++; end
    tick;
    ntests++; if (o_rd_valid !== 1'b0 || o_rd_data !== 12'hABC) begin
      $display("FAIL read_hold: valid=%b data=%h required 0 abc", o_rd_valid, o_rd_data); nfail++; end
  endtask

  task automatic test_collision;
    i_px_clk = 1; i_rd_req = 1; i_rd_addr = 19'd9;
    i_wr_req = 1; i_wr_addr = 19'd7; i_wr_data = 12'h123;
    #1;
    ntests++; if (o_mem_we !== 1'b0 || o_mem_addr !== 20'h00009) begin
      $display("FAIL coll_read_wins: we=%b addr=%h required 0 00009", o_mem_we, o_mem_addr); nfail++; end
    tick;
    i_px_clk = 0; i_rd_req = 0;
    #1;
    ntests++; if (o_mem_we !== 1'b1 || o_mem_addr !== 20'h80007 || o_mem_wdata !== 12'h123 || o_wr_ack !== 1'b0) begin
      $display("FAIL coll_write: we=%b addr=%h wdata=%h ack=%b required 1 80007 123 0", o_mem_we, o_mem_addr, o_mem_wdata, o_wr_ack); nfail++; end
    tick;
    ntests++; if (o_wr_ack !== 1'b1 || o_mem_we !== 1'b0) begin
      $display("FAIL coll_ack: ack=%b we=%b required 1 0", o_wr_ack, o_mem_we); nfail++; end
    i_wr_req = 0;
    tick;
    ntests++; if (o_wr_ack !== 1'b0 || ram[20'h80007] !== 12'h123) begin
      $display("FAIL coll_ram: ack=%b ram=%h required 0 123", o_wr_ack, ram[20'h80007]); nfail++; end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp_we = 7'b0101001;
    logic [6:0] exp_ack = 7'b1010010;
    logic [18:0] a = 19'd16;
    int writes = 0;
    int acks = 0;
    i_wr_req = 1; i_wr_data = 12'h5A5;
    for (int c = 0; c < 7; c++) begin
      if (exp_ack[c]) a = a + 19'd1;
      i_wr_addr = a;
      i_px_clk = (c == 2); i_rd_req = (c == 2); i_rd_addr = 19'd2;
      #1;
      ntests++; if (o_mem_we !== exp_we[c] || o_wr_ack !== exp_ack[c]) begin
        $display("FAIL b2b_cycle%0d: we=%b ack=%b required %b %b", c, o_mem_we, o_wr_ack, exp_we[c], exp_ack[c]); nfail++; end
      if (exp_we[c]) begin
        ntests++; if (o_mem_addr !== {1'b1, a}) begin
          $display("FAIL b2b_addr%0d: addr=%h required %h", c, o_mem_addr, {1'b1, a}); nfail++; end
      end
      writes += int'(o_mem_we);
      acks += int'(o_wr_ack);
      tick;
    end
    i_wr_req = 0; i_px_clk = 0; i_rd_req = 0;
    ntests++; if (writes != 3 || acks != 3) begin
      $display("FAIL b2b_counts: writes=%0d acks=%0d required 3 3", writes, acks); nfail++; end
    tick;
  endtask

  task automatic test_swap;
    i_swap_req = 1;
    tick;
    i_swap_req = 0; i_wr_req = 1; i_wr_addr = 19'h20; i_wr_data = 12'h456;
    #1;
    ntests++; if (o_swap_busy !== 1'b1) begin
      $display("FAIL swap_busy: got %b required 1", o_swap_busy); nfail++; end
    for (int c = 0; c < 10; c++) begin
      i_vblank_start = (c == 9);
      #1;
      ntests++; if (o_mem_we !== 1'b0 || o_disp_page !== 1'b0) begin
        $display("FAIL swap_stall%0d: we=%b page=%b required 0 0", c, o_mem_we, o_disp_page); nfail++; end
      tick;
    end
    i_vblank_start = 0;
    #1;
    ntests++; if (o_disp_page !== 1'b1 || o_swap_done !== 1'b1 || o_swap_busy !== 1'b0) begin
      $display("FAIL swap_toggle: page=%b done=%b busy=%b required 1 1 0", o_disp_page, o_swap_done, o_swap_busy); nfail++; end
    ntests++; if (o_mem_we !== 1'b1 || o_mem_addr !== 20'h00020 || o_mem_wdata !== 12'h456) begin
      $display("FAIL swap_write: we=%b addr=%h wdata=%h required 1 00020 456", o_mem_we, o_mem_addr, o_mem_wdata); nfail++; end
    tick;
    ntests++; if (o_wr_ack !== 1'b1 || o_swap_done !== 1'b0) begin
      $display("FAIL swap_ack: ack=%b done=%b required 1 0", o_wr_ack, o_swap_done); nfail++; end
    i_wr_req = 0;
    tick;
  endtask

  task automatic test_simultaneous;
    i_swap_req = 1; i_vblank_start = 1;
    tick;
    i_swap_req = 0; i_vblank_start = 0;
    #1;
    ntests++; if (o_disp_page !== 1'b0 || o_swap_done !== 1'b1 || o_swap_busy !== 1'b0) begin
      $display("FAIL simul_toggle: page=%b done=%b busy=%b required 0 1 0", o_disp_page, o_swap_done, o_swap_busy); nfail++; end
    tick;
    ntests++; if (o_disp_page !== 1'b0 || o_swap_done !== 1'b0) begin
      $display("FAIL simul_once: page=%b done=%b required 0 0", o_disp_page, o_swap_done); nfail++; end
    i_swap_req = 1;
    tick;
    tick;
    i_swap_req = 0;
    tick;
    i_vblank_start = 1;
    tick;
    i_vblank_start = 0;
    i_swap_req = 1;
    #1;
    ntests++; if (o_disp_page !== 1'b1 || o_swap_done !== 1'b1) begin
      $display("FAIL dup_toggle: page=%b done=%b required 1 1", o_disp_page, o_swap_done); nfail++; end
    tick;
    i_swap_req = 0;
    #1;
    ntests++; if (o_disp_page !== 1'b1 || o_swap_done !== 1'b0 || o_swap_busy !== 1'b1) begin
      $display("FAIL done_cycle_req: page=%b done=%b busy=%b required 1 0 1", o_disp_page, o_swap_done, o_swap_busy); nfail++; end
  endtask

  initial begin
    for (int i = 0; i < (1 << 20); i++) ram[i] = 12'h000;
    i_sclr = 1; i_px_clk = 0; i_rd_req = 0; i_rd_addr = '0;
    i_wr_req = 0; i_wr_addr = '0; i_wr_data = '0;
    i_swap_req = 0; i_vblank_start = 0;
    tick;
    tick;
    i_sclr = 0;
    #1;
    test_reset;
    test_read;
    test_collision;
    test_back_to_back;
    test_swap;
    test_simultaneous;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
